// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
// Shared types and defaults for the stack controller slice.
//   stack_op_t    : request opcodes (values 5..7 are NOPs)
//   stack_state_t : controller FSM states
//   DEF_*         : default widths and stack depth
//   is_write_op / is_read_op : opcode classification helpers
// ---------------------------------------------------------------------------
package stack_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_PC_W   = 10;
   localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

   typedef enum logic [2:0] {
      OP_PUSH = 3'd0,
      OP_POP  = 3'd1,
      OP_CALL = 3'd2,
      OP_RET  = 3'd3,
      OP_RETI = 3'd4
   } stack_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_CAP  = 2'd3
   } stack_state_t;

   // Operations that store a word below the current stack pointer.
   function automatic logic is_write_op(input logic [2:0] op);
      return (op == OP_PUSH) || (op == OP_CALL);
   endfunction

   // Operations that fetch the word at the current stack pointer.
   function automatic logic is_read_op(input logic [2:0] op);
      return (op == OP_POP) || (op == OP_RET) || (op == OP_RETI);
   endfunction

endpackage

// File: rtl/stack_depth_guard.sv
// ---------------------------------------------------------------------------
// stack_depth_guard
// Tracks how many words are live on the stack (0..DEPTH) and flags requests
// that would overflow or underflow it. Only instantiated when STACK_GUARD_EN
// is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : external stack pointer load; forgets the current depth
//   inc, dec  : a push / pop actually took place this cycle
//   chk_push  : incoming request is PUSH/CALL
//   chk_pop   : incoming request is POP/RET/RETI
//   ovf, unf  : incoming request would overflow / underflow
// ---------------------------------------------------------------------------
module stack_depth_guard
   import stack_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   input  logic dec,
   input  logic chk_push,
   input  logic chk_pop,
   output logic ovf,
   output logic unf
);

   // One extra bit so a completely full stack is distinguishable from empty.
   localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

   logic [ADDR_W:0] depth;

   // NOTE: sequential state is assigned with <= so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         depth <= '0;
      end else if (inc && !dec && depth != FULL) begin
         depth <= depth + ONE;
      end else if (dec && !inc && depth != '0) begin
         depth <= depth - ONE;
      end
   end

   assign ovf = chk_push && (depth == FULL);
   assign unf = chk_pop  && (depth == '0);

endmodule

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
// Sequences PUSH/POP/CALL/RET/RETI between the control unit and the stack
// pointer / scratch RAM pair. Writes take one cycle (WR), reads take two
// (RD then CAP, because the RAM read is synchronous).
// Optional feature: define STACK_GUARD_EN to add a depth counter that blocks
// overflowing pushes and underflowing pops and reports them on err_ovf /
// err_unf. Without it the stack wraps silently and err_* are tied low.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid/req_ready/req_op  : request handshake and opcode
//   push_data, pc_in            : PUSH data, CALL return address
//   sp_in, sp_ld                : current stack pointer, external SP load
//   sp_incr, sp_decr            : stack pointer strobes
//   ram_addr/ram_wdata/ram_we   : scratch RAM write/read port
//   ram_rdata                   : scratch RAM read data (one cycle latency)
//   done, iret                  : completion pulse, RETI pulse
//   pop_data, ret_pc            : held results of POP and RET/RETI
//   err_ovf, err_unf            : guard error pulses
// ---------------------------------------------------------------------------
module stack_ctrl
   import stack_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int PC_W   = DEF_PC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [DATA_W-1:0] push_data,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [ADDR_W-1:0] sp_in,
   input  logic              sp_ld,
   output logic              sp_incr,
   output logic              sp_decr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [PC_W-1:0]   ram_wdata,
   output logic              ram_we,
   input  logic [PC_W-1:0]   ram_rdata,
   output logic              done,
   output logic [DATA_W-1:0] pop_data,
   output logic [PC_W-1:0]   ret_pc,
   output logic              iret,
   output logic              err_ovf,
   output logic              err_unf
);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] WR   = ST_WR;
   localparam logic [1:0] RD   = ST_RD;
   localparam logic [1:0] CAP  = ST_CAP;

   logic [1:0]        state;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] data_q;
   logic [PC_W-1:0]   pc_q;
   // act_q: the captured operation really touches RAM/SP. Low for NOPs and
   // for guard-rejected requests, which still walk the FSM to produce done.
   logic              act_q;
   logic              ovf_hit;
   logic              unf_hit;

   assign req_ready = (state == IDLE);

`ifdef STACK_GUARD_EN
   stack_depth_guard #(
      .ADDR_W (ADDR_W),
      .DEPTH  (1 << ADDR_W)
   ) u_guard (
      .clk      (clk),
      .rst      (rst),
      .clr      (sp_ld),
      .inc      (sp_decr),
      .dec      (sp_incr),
      .chk_push (is_write_op(req_op)),
      .chk_pop  (is_read_op(req_op)),
      .ovf      (ovf_hit),
      .unf      (unf_hit)
   );

   assign err_ovf = !rst && (state == WR)  && !act_q && is_write_op(op_q);
   assign err_unf = !rst && (state == CAP) && !act_q && is_read_op(op_q);
`else
   logic unused_sp_ld;
   assign unused_sp_ld = sp_ld;
   assign ovf_hit      = 1'b0;
   assign unf_hit      = 1'b0;
   assign err_ovf      = 1'b0;
   assign err_unf      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= '0;
         data_q   <= '0;
         pc_q     <= '0;
         act_q    <= 1'b0;
         pop_data <= '0;
         ret_pc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q   <= req_op;
                  data_q <= push_data;
                  pc_q   <= pc_in;
                  if (is_write_op(req_op)) begin
                     state <= WR;
                     act_q <= !ovf_hit;
                  end else if (is_read_op(req_op)) begin
                     state <= RD;
                     act_q <= !unf_hit;
                  end else begin
                     // NOP borrows the one-cycle WR slot with RAM/SP idle.
                     state <= WR;
                     act_q <= 1'b0;
                  end
               end
            end
            WR:  state <= IDLE;
            RD:  state <= CAP;
            CAP: begin
               state <= IDLE;
               if (act_q) begin
                  if (op_q == OP_POP) begin
                     pop_data <= ram_rdata[DATA_W-1:0];
                  end else begin
                     ret_pc <= ram_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are decoded from the state but suppressed while rst is high, so
   // an aborted operation issues nothing in the reset cycle.
   // NOTE: every output gets a default first so always_comb cannot infer a
   // latch on paths that do not assign it.
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      sp_incr   = 1'b0;
      sp_decr   = 1'b0;
      done      = 1'b0;
      iret      = 1'b0;
      if (!rst) begin
         case (state)
            WR: begin
               done = 1'b1;
               if (act_q) begin
                  ram_addr  = sp_in - ADDR_W'(1);
                  ram_we    = 1'b1;
                  sp_decr   = 1'b1;
                  ram_wdata = (op_q == OP_CALL) ? pc_q : PC_W'(data_q);
               end
            end
            RD: begin
               if (act_q) begin
                  ram_addr = sp_in;
                  sp_incr  = 1'b1;
               end
            end
            CAP: begin
               done = 1'b1;
               iret = act_q && (op_q == OP_RETI);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl
// Self-checking bench for stack_ctrl. Surrounds the DUT with a stack pointer
// register and a synchronous scratch RAM, and predicts every operation from
// a simple array/arithmetic model of a descending stack.
// ---------------------------------------------------------------------------
module tb_stack_ctrl;

`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct packed {
      logic       req_ready;
      logic [7:0] ram_addr;
      logic [9:0] ram_wdata;
      logic       ram_we;
      logic       sp_incr;
      logic       sp_decr;
      logic       done;
      logic       iret;
      logic       err_ovf;
      logic       err_unf;
   } cyc_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [2:0] req_op = 3'd0;
   logic [7:0] push_data = 8'h00;
   logic [9:0] pc_in = 10'h000;
   logic [7:0] sp_in;
   logic       sp_ld = 1'b0;
   logic [7:0] sp_ld_val = 8'h00;
   logic       sp_incr, sp_decr, ram_we, done, iret, err_ovf, err_unf;
   logic [7:0] ram_addr;
   logic [9:0] ram_wdata;
   logic [9:0] ram_rdata = 10'h000;
   logic [7:0] pop_data;
   logic [9:0] ret_pc;

   int n_checks = 0;
   int n_fail   = 0;

   // Environment: stack pointer register and synchronous scratch RAM.
   logic [7:0] env_sp = 8'h00;
   logic [9:0] tb_ram [256] = '{default: 10'h000};
   assign sp_in = env_sp;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) tb_ram[ram_addr] <= ram_wdata;
      ram_rdata <= tb_ram[ram_addr];
      if (sp_ld)        env_sp <= sp_ld_val;
      else if (sp_incr) env_sp <= env_sp + 8'd1;
      else if (sp_decr) env_sp <= env_sp - 8'd1;
   end

   stack_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .push_data (push_data),
      .pc_in     (pc_in),
      .sp_in     (sp_in),
      .sp_ld     (sp_ld),
      .sp_incr   (sp_incr),
      .sp_decr   (sp_decr),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata),
      .done      (done),
      .pop_data  (pop_data),
      .ret_pc    (ret_pc),
      .iret      (iret),
      .err_ovf   (err_ovf),
      .err_unf   (err_unf)
   );

   // ---------------- reference model ----------------
   logic [9:0] m_mem [256] = '{default: 10'h000};
   logic [7:0] m_sp    = 8'h00;
   int         m_depth = 0;
   logic [7:0] m_pop   = 8'h00;
   logic [9:0] m_ret   = 10'h000;
   cyc_t       e_c [1:3];
   cyc_t       a_c [1:3];

   // Predicts the three cycles after accept and advances the model stack.
   function automatic void m_predict(input logic [2:0] op, input logic [7:0] d,
                                     input logic [9:0] pc);
      logic [7:0] a;
      logic [9:0] val;
      for (int k = 1; k <= 3; k++) e_c[k] = '0;
      e_c[2].req_ready = 1'b1;
      e_c[3].req_ready = 1'b1;
      if (op == 3'd0 || op == 3'd2) begin
         e_c[1].done = 1'b1;
         if (GUARD && m_depth == 256) begin
            e_c[1].err_ovf = 1'b1;
         end else begin
            a   = m_sp - 8'd1;
            val = (op == 3'd2) ? pc : {2'b00, d};
            e_c[1].ram_we    = 1'b1;
            e_c[1].sp_decr   = 1'b1;
            e_c[1].ram_addr  = a;
            e_c[1].ram_wdata = val;
            m_mem[a] = val;
            m_sp     = a;
            m_depth++;
         end
      end else if (op == 3'd1 || op == 3'd3 || op == 3'd4) begin
         e_c[2].req_ready = 1'b0;
         e_c[2].done      = 1'b1;
         if (GUARD && m_depth == 0) begin
            e_c[2].err_unf = 1'b1;
         end else begin
            e_c[1].sp_incr  = 1'b1;
            e_c[1].ram_addr = m_sp;
            val = m_mem[m_sp];
            if (op == 3'd1) m_pop = val[7:0];
            else            m_ret = val;
            e_c[2].iret = (op == 3'd4);
            m_sp = m_sp + 8'd1;
            m_depth--;
         end
      end else begin
         e_c[1].done = 1'b1;
      end
   endfunction

   // Address/data only carry meaning while the matching strobe is active.
   function automatic cyc_t sample();
      cyc_t s;
      s.req_ready = req_ready;
      s.ram_addr  = (ram_we || sp_incr) ? ram_addr : 8'h00;
      s.ram_wdata = ram_we ? ram_wdata : 10'h000;
      s.ram_we    = ram_we;
      s.sp_incr   = sp_incr;
      s.sp_decr   = sp_decr;
      s.done      = done;
      s.iret      = iret;
      s.err_ovf   = err_ovf;
      s.err_unf   = err_unf;
      return s;
   endfunction

   // ---------------- drivers ----------------
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_pop = 8'h00;
      m_ret = 10'h000;
      m_depth = 0;
   endtask

   task automatic set_sp(input logic [7:0] v);
      @(negedge clk);
      sp_ld = 1'b1;
      sp_ld_val = v;
      @(negedge clk);
      sp_ld = 1'b0;
      m_sp = v;
      m_depth = 0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [7:0] d, input logic [9:0] pc);
      int waited = 0;
      m_predict(op, d, pc);
      @(negedge clk);
      req_valid = 1'b1;
      req_op = op;
      push_data = d;
      pc_in = pc;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         a_c[k] = sample();
         if (k < 3) @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({sp_incr, sp_decr, ram_we, done, iret, err_ovf, err_unf} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_strobes_in_rst: got %b required 0000000",
                  {sp_incr, sp_decr, ram_we, done, iret, err_ovf, err_unf});
      end
      apply_reset();
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b required 1", req_ready);
      end
      n_checks++;
      if ({pop_data, ret_pc, ram_addr, ram_wdata} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_values: got %h required 0", {pop_data, ret_pc, ram_addr, ram_wdata});
      end
      n_checks++;
      if ({sp_incr, sp_decr, ram_we, done, iret, err_ovf, err_unf} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_strobes: got %b required 0000000",
                  {sp_incr, sp_decr, ram_we, done, iret, err_ovf, err_unf});
      end
   endtask

   task automatic test_push_pop();
      set_sp(8'hFF);
      run_op(3'd0, 8'hA5, 10'h000);
      n_checks++;
      if ({a_c[1].ram_addr, a_c[1].ram_wdata} !== {8'hFE, 10'h0A5}) begin
         n_fail++;
         $display("FAIL push_addr_data: got %h/%h required fe/0a5", a_c[1].ram_addr, a_c[1].ram_wdata);
      end
      n_checks++;
      if ({a_c[1].ram_we, a_c[1].sp_decr, a_c[1].done, a_c[1].req_ready, a_c[2].req_ready} !== 5'b11101) begin
         n_fail++;
         $display("FAIL push_strobes: got we/decr/done/rdy1/rdy2=%b%b%b%b%b required 11101",
                  a_c[1].ram_we, a_c[1].sp_decr, a_c[1].done, a_c[1].req_ready, a_c[2].req_ready);
      end
      run_op(3'd1, 8'h00, 10'h000);
      n_checks++;
      if ({a_c[1].ram_addr, a_c[1].sp_incr, a_c[1].ram_we, a_c[1].done} !== {8'hFE, 3'b100}) begin
         n_fail++;
         $display("FAIL pop_rd: got addr=%h incr=%b we=%b done=%b required fe 1 0 0",
                  a_c[1].ram_addr, a_c[1].sp_incr, a_c[1].ram_we, a_c[1].done);
      end
      n_checks++;
      if (a_c[2].done !== 1'b1 || pop_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL pop_cap: got done=%b pop_data=%h required 1 a5", a_c[2].done, pop_data);
      end
   endtask

   task automatic test_call_reti();
      set_sp(8'h10);
      run_op(3'd2, 8'h00, 10'h2C3);
      n_checks++;
      if ({a_c[1].ram_addr, a_c[1].ram_wdata, a_c[1].ram_we} !== {8'h0F, 10'h2C3, 1'b1}) begin
         n_fail++;
         $display("FAIL call_write: got %h/%h we=%b required 0f/2c3 we=1",
                  a_c[1].ram_addr, a_c[1].ram_wdata, a_c[1].ram_we);
      end
      run_op(3'd4, 8'h00, 10'h000);
      n_checks++;
      if ({a_c[2].done, a_c[2].iret, a_c[1].iret, a_c[3].iret} !== 4'b1100 || ret_pc !== 10'h2C3) begin
         n_fail++;
         $display("FAIL reti: got done=%b iret=%b%b%b ret_pc=%h required 1 010 2c3",
                  a_c[2].done, a_c[1].iret, a_c[2].iret, a_c[3].iret, ret_pc);
      end
   endtask

   task automatic test_back_to_back();
      set_sp(8'h00);
      m_predict(3'd0, 8'h11, 10'h000);
      m_predict(3'd1, 8'h00, 10'h000);
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 3'd0;
      push_data = 8'h11;
      @(posedge clk);
      @(negedge clk);
      req_op = 3'd1;
      n_checks++;
      if ({ram_addr, ram_wdata, ram_we, sp_decr, done, req_ready} !== {8'hFF, 10'h011, 4'b1110}) begin
         n_fail++;
         $display("FAIL wrap_push: got addr=%h wdata=%h we/decr/done/rdy=%b%b%b%b required ff 011 1110",
                  ram_addr, ram_wdata, ram_we, sp_decr, done, req_ready);
      end
      @(negedge clk);
      n_checks++;
      if ({req_ready, sp_incr, done} !== 3'b100) begin
         n_fail++;
         $display("FAIL b2b_gap: got rdy/incr/done=%b%b%b required 100", req_ready, sp_incr, done);
      end
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++;
      if ({sp_incr, ram_addr} !== {1'b1, 8'hFF}) begin
         n_fail++;
         $display("FAIL b2b_second_rd: got incr=%b addr=%h required 1 ff", sp_incr, ram_addr);
      end
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (pop_data !== 8'h11 || sp_in !== 8'h00) begin
         n_fail++;
         $display("FAIL b2b_pop_wrap: got pop_data=%h sp=%h required 11 00", pop_data, sp_in);
      end
   endtask

   task automatic test_nop();
      for (int op = 5; op <= 7; op++) begin
         run_op(3'(op), 8'hFF, 10'h3FF);
         n_checks++;
         if (a_c[1] !== e_c[1] || a_c[1].done !== 1'b1 || a_c[2].req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL nop_%0d: got %h required %h", op, a_c[1], e_c[1]);
         end
      end
      n_checks++;
      if (pop_data !== m_pop) begin
         n_fail++;
         $display("FAIL nop_pop_held: got %h required %h", pop_data, m_pop);
      end
   endtask

   task automatic test_reset_mid_op();
      set_sp(8'h40);
      run_op(3'd0, 8'h5A, 10'h000);
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 3'd1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({sp_incr, sp_decr, ram_we, done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_cycle_strobes: got %b required 0000", {sp_incr, sp_decr, ram_we, done});
      end
      @(negedge clk);
      rst = 1'b0;
      m_pop = 8'h00;
      m_ret = 10'h000;
      m_depth = 0;
      #1;
      n_checks++;
      if ({req_ready, done, sp_incr, sp_decr, ram_we, iret} !== 6'b100000 || pop_data !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_abort: got rdy/done/incr/decr/we/iret=%b pop_data=%h required 100000 00",
                  {req_ready, done, sp_incr, sp_decr, ram_we, iret}, pop_data);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || sp_in !== 8'h3F) begin
         n_fail++;
         $display("FAIL rst_no_late_done: got done=%b sp=%h required 0 3f", done, sp_in);
      end
   endtask

   task automatic test_random();
      logic [2:0] op;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 15) == 0) set_sp(8'($urandom));
         op = 3'($urandom_range(0, 7));
         run_op(op, 8'($urandom), 10'($urandom));
         for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if (a_c[k] !== e_c[k]) begin
               n_fail++;
               $display("FAIL rand_%0d_op%0d_cyc%0d: got %h required %h", i, op, k, a_c[k], e_c[k]);
            end
         end
         n_checks++;
         if (pop_data !== m_pop || ret_pc !== m_ret) begin
            n_fail++;
            $display("FAIL rand_%0d_results: got pop=%h ret=%h required pop=%h ret=%h",
                     i, pop_data, ret_pc, m_pop, m_ret);
         end
      end
   endtask

`ifdef STACK_GUARD_EN
   task automatic test_guard();
      apply_reset();
      run_op(3'd1, 8'h00, 10'h000);
      n_checks++;
      if ({a_c[1].sp_incr, a_c[2].sp_incr, a_c[2].err_unf, a_c[2].done, a_c[1].err_unf} !== 5'b00110
          || pop_data !== 8'h00) begin
         n_fail++;
         $display("FAIL guard_unf_pop: got incr=%b%b unf=%b done=%b early_unf=%b pop=%h required 00 1 1 0 00",
                  a_c[1].sp_incr, a_c[2].sp_incr, a_c[2].err_unf, a_c[2].done, a_c[1].err_unf, pop_data);
      end
      run_op(3'd4, 8'h00, 10'h000);
      n_checks++;
      if ({a_c[2].err_unf, a_c[2].iret} !== 2'b10) begin
         n_fail++;
         $display("FAIL guard_unf_reti: got unf=%b iret=%b required 1 0", a_c[2].err_unf, a_c[2].iret);
      end
      for (int i = 0; i < 256; i++) begin
         run_op(3'd0, 8'(i), 10'h000);
         n_checks++;
         if (a_c[1] !== e_c[1]) begin
            n_fail++;
            $display("FAIL guard_fill_%0d: got %h required %h", i, a_c[1], e_c[1]);
         end
      end
      run_op(3'd0, 8'hEE, 10'h000);
      n_checks++;
      if ({a_c[1].err_ovf, a_c[1].done, a_c[1].ram_we, a_c[1].sp_decr} !== 4'b1100) begin
         n_fail++;
         $display("FAIL guard_ovf: got ovf/done/we/decr=%b%b%b%b required 1100",
                  a_c[1].err_ovf, a_c[1].done, a_c[1].ram_we, a_c[1].sp_decr);
      end
      run_op(3'd1, 8'h00, 10'h000);
      n_checks++;
      if (a_c[1].sp_incr !== 1'b1 || pop_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL guard_pop_after_full: got incr=%b pop=%h required 1 ff", a_c[1].sp_incr, pop_data);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_push_pop();
      test_call_reti();
      test_back_to_back();
      test_nop();
      test_reset_mid_op();
      test_random();
`ifdef STACK_GUARD_EN
      test_guard();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
